// File: rtl/div_pkg.sv
// Shared types for the sequential divider: FSM state encoding and default width.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DIV_W_DEFAULT = 8;

endpackage

// File: rtl/seq_divider_param.sv
// Sequential restoring divider, one quotient bit per cycle, busy/done handshake.
// Define DIV_SIGNED_EN to honour sgn (signed magnitudes plus sign fix-up in FIX).
import div_pkg::*;

module seq_divider_param #(
  parameter int W = DIV_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sgn,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         dbz
);

  localparam int CNT_W = (W > 2) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(W - 1);

  // Handshake: start is accepted on any rising edge where ready && start.
  // done is a one-cycle pulse; quotient/remainder/dbz hold until the next result.
  div_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [W:0]     rem;
  logic [W-1:0]   qr;
  logic [W-1:0]   dsr;
  logic           zero_div;
  logic           q_neg;
  logic           r_neg;
  logic           a_neg;
  logic           b_neg;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [W+1:0]   trial;
  logic           trial_ge;

`ifdef DIV_SIGNED_EN
  assign a_neg = sgn & dividend[W-1];
  assign b_neg = sgn & divisor[W-1];
`else
  logic sgn_unused;
  assign sgn_unused = sgn;
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif

  // W-bit unsigned magnitude also covers |-2^(W-1)|.
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor  : divisor;

  assign trial    = {rem, qr[W-1]} - {2'b00, dsr};
  assign trial_ge = ~trial[W+1];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A zero divisor skips CALC and lets FIX load the flagged result.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start)             state_nxt = (divisor == '0) ? FIX : CALC;
        else if (state == DONE) state_nxt = IDLE;
      end
      CALC:    if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE) || (state == DONE);
    busy  = (state == CALC) || (state == FIX);
    done  = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      rem       <= '0;
      qr        <= '0;
      dsr       <= '0;
      zero_div  <= 1'b0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            rem      <= '0;
            cnt      <= CNT_MAX;
            zero_div <= (divisor == '0);
            qr       <= (divisor == '0) ? dividend : a_mag;
            dsr      <= b_mag;
            q_neg    <= a_neg ^ b_neg;
            r_neg    <= a_neg;
          end
        end
        CALC: begin
          rem <= trial_ge ? trial[W:0] : {rem[W-1:0], qr[W-1]};
          qr  <= {qr[W-2:0], trial_ge};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (zero_div) begin
            quotient  <= '1;
            remainder <= qr;
            dbz       <= 1'b1;
          end else begin
            quotient  <= q_neg ? -qr : qr;
            remainder <= r_neg ? -rem[W-1:0] : rem[W-1:0];
            dbz       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_param.sv
// Self-checking bench for seq_divider_param: W=8 and W=16 instances, vector table,
// random ops against an arithmetic model, and multi-cycle corner sequences.
module tb_seq_divider_param;

`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start8, sgn8, ready8, busy8, done8, dbz8;
  logic [7:0]  a8, b8, q8, r8;
  logic        start16, sgn16, ready16, busy16, done16, dbz16;
  logic [15:0] a16, b16, q16, r16;

  seq_divider_param #(.W(8)) u_div8 (
    .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .dividend(a8), .divisor(b8),
    .ready(ready8), .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .dbz(dbz8)
  );

  seq_divider_param #(.W(16)) u_div16 (
    .clk(clk), .rst(rst), .start(start16), .sgn(sgn16), .dividend(a16), .divisor(b16),
    .ready(ready16), .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .dbz(dbz16)
  );

  int checks = 0;
  int failures = 0;
  logic [16:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: plain integer division, truncating toward zero in signed mode.
  function automatic logic [16:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int sa, sb, qi, ri;
    logic [7:0] qv, rv;
    if (b == 8'd0) return {1'b1, 8'hFF, a};
    if (s && SIGNED_BUILD) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      qi = sa / sb;
      ri = sa % sb;
      qv = qi[7:0];
      rv = ri[7:0];
    end else begin
      qv = a / b;
      rv = a % b;
    end
    return {1'b0, qv, rv};
  endfunction

  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int n = 0;
    while (!ready8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic wait_done8(output int lat);
    logic seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done8) seen = 1'b1;
    end
    check("done8_seen", 32'(seen), 32'd1);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [7:0] eq, input logic [7:0] er, input logic ez, input int elat);
    int lat;
    launch8(a, b, s);
    wait_done8(lat);
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_q"}, 32'(q8), 32'(eq));
    check({tag, "_r"}, 32'(r8), 32'(er));
    check({tag, "_dbz"}, 32'(dbz8), 32'(ez));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done8), 32'd0);
    check({tag, "_held"}, {15'd0, dbz8, q8, r8}, {15'd0, ez, eq, er});
  endtask

  initial begin
    int lat, cyc, nd;
    int t [3];
    logic [16:0] e;
    logic [7:0] ra, rb;
    logic rs;
    logic [15:0] dq [3];
    logic [15:0] dr [3];

    vecs[0] = '{8'd45,  8'd7,   1'b0, 8'd6,   8'd3,   1'b0, 9};
    vecs[1] = '{8'h11,  8'h11,  1'b0, 8'd1,   8'd0,   1'b0, 9};
    vecs[2] = '{8'd0,   8'd5,   1'b0, 8'd0,   8'd0,   1'b0, 9};
    vecs[3] = '{8'd200, 8'd0,   1'b0, 8'hFF,  8'd200, 1'b1, 1};
    vecs[4] = '{8'd255, 8'd1,   1'b0, 8'd255, 8'd0,   1'b0, 9};
    vecs[5] = '{8'd7,   8'd45,  1'b0, 8'd0,   8'd7,   1'b0, 9};
    vecs[6] = '{8'd255, 8'd255, 1'b0, 8'd1,   8'd0,   1'b0, 9};
`ifdef DIV_SIGNED_EN
    vecs[7] = '{8'd211, 8'd7,   1'b1, 8'hFA,  8'hFD,  1'b0, 9};
    vecs[8] = '{8'h80,  8'hFF,  1'b1, 8'h80,  8'd0,   1'b0, 9};
`else
    vecs[7] = '{8'd211, 8'd7,   1'b1, 8'd30,  8'd1,   1'b0, 9};
    vecs[8] = '{8'h80,  8'hFF,  1'b1, 8'd0,   8'h80,  1'b0, 9};
`endif

    rst = 1'b1;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sgn16 = 1'b0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready8", {26'd0, ready8, busy8, done8, dbz8, 2'b00}, {26'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00});
    check("rst_res8", {16'd0, q8, r8}, 32'd0);
    check("rst_ready16", {28'd0, ready16, busy16, done16, dbz16}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    check("rst_res16", {q16, r16}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
           vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].lat);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      exp_q.push_back(model8(ra, rb, rs));
      launch8(ra, rb, rs);
      wait_done8(lat);
      e = exp_q.pop_front();
      check($sformatf("rnd%0d_lat", i), 32'(lat), (rb == 8'd0) ? 32'd1 : 32'd9);
      check($sformatf("rnd%0d_res a=%0d b=%0d s=%0d", i, ra, rb, rs), {15'd0, dbz8, q8, r8}, {15'd0, e});
    end

    // New operands and start pulse while busy must not disturb the running op.
    launch8(8'd45, 8'd7, 1'b0);
    @(posedge clk); #1;
    check("busy_mid", {30'd0, busy8, ready8}, {30'd0, 1'b1, 1'b0});
    a8 = 8'd100; b8 = 8'd3; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int i = 0; i < 40 && !done8; i++) begin
      @(posedge clk); #1;
    end
    check("ignore_start_res", {15'd0, dbz8, q8, r8}, {15'd0, 1'b0, 8'd6, 8'd3});

    // Reset in the middle of CALC aborts and clears everything.
    launch8(8'd99, 8'd4, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_flags", {28'd0, ready8, busy8, done8, dbz8}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    check("midrst_res", {16'd0, q8, r8}, 32'd0);
    nd = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done8) nd++;
    end
    check("midrst_no_done", 32'(nd), 32'd0);

    // W=16 with start held high: results every W+2 cycles.
    a16 = 16'd1000; b16 = 16'd33; sgn16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    cyc = 0; nd = 0;
    while (nd < 3 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (done16) begin
        t[nd] = cyc; dq[nd] = q16; dr[nd] = r16;
        nd++;
      end
    end
    start16 = 1'b0;
    check("b2b_count", 32'(nd), 32'd3);
    if (nd == 3) begin
      check("w16_lat", 32'(t[0]), 32'd17);
      check("b2b_gap1", 32'(t[1] - t[0]), 32'd18);
      check("b2b_gap2", 32'(t[2] - t[1]), 32'd18);
      for (int k = 0; k < 3; k++)
        check($sformatf("w16_res%0d", k), {dq[k], dr[k]}, {16'd30, 16'd10});
    end
    repeat (25) @(posedge clk);
    #1;
    check("w16_idle", {30'd0, ready16, busy16}, {30'd0, 1'b1, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
